// File: rtl/demux6_buf.sv
// demux6_buf: buffered 1-to-6 demultiplexer with a two-entry skid buffer.
// in_ready comes from registered state only, so no consumer ready reaches the producer.
module demux6_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [5:0]       out_valid,
    input  logic [5:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_dst
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] head_data;
    logic [2:0]       head_dst;
    logic [WIDTH-1:0] skid_data;
    logic [2:0]       skid_dst;
    logic [2:0]       sel_norm;
    logic             accept;
    logic             drain;
    logic             ld_head_in;
    logic             ld_head_skid;
    logic             ld_skid;

    assign sel_norm  = (in_sel > 3'd4) ? 3'd5 : in_sel;
    assign in_ready  = ~rst & (state != TWO);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state != EMPTY) ? (6'(1) << head_dst) : 6'b0;
    assign drain     = |(out_valid & out_ready);
    assign out_data  = head_data;
    assign out_dst   = head_dst;

    // Next state and register load enables from accept/drain.
    always_comb begin
        state_nx     = state;
        ld_head_in   = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx   = ONE;
                    ld_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    ld_head_in = 1'b1;
                end else if (accept) begin
                    state_nx = TWO;
                    ld_skid  = 1'b1;
                end else if (drain) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_nx     = ONE;
                    ld_head_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // State and storage registers; reset discards both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_data <= '0;
            head_dst  <= '0;
            skid_data <= '0;
            skid_dst  <= '0;
        end else begin
            state <= state_nx;
            if (ld_head_in) begin
                head_data <= in_data;
                head_dst  <= sel_norm;
            end else if (ld_head_skid) begin
                head_data <= skid_data;
                head_dst  <= skid_dst;
            end
            if (ld_skid) begin
                skid_data <= in_data;
                skid_dst  <= sel_norm;
            end
        end
    end

endmodule

// File: tb/tb_demux6_buf.sv
// tb_demux6_buf: directed vector table plus a streaming sequence.
// Inputs are driven and outputs checked on the falling edge.
module tb_demux6_buf;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic [5:0] out_valid;
    logic [5:0] out_ready;
    logic [7:0] out_data;
    logic [2:0] out_dst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic [2:0] sel;
        logic [5:0] ordy;
        logic       chk_out;
        logic       erdy;
        logic [5:0] eov;
        logic [7:0] edat;
        logic [2:0] edst;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    demux6_buf #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dst   (out_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;

        //           rst iv  d      sel   ordy       chk rdy  eov        edat   edst
        vecs[0]  = '{1, 1, 8'hFF, 3'd2, 6'b000000, 0, 0, 6'b000000, 8'h00, 3'd0};
        vecs[1]  = '{1, 1, 8'hFF, 3'd2, 6'b000000, 1, 0, 6'b000000, 8'h00, 3'd0};
        vecs[2]  = '{0, 1, 8'hA5, 3'd3, 6'b001000, 1, 1, 6'b000000, 8'h00, 3'd0};
        vecs[3]  = '{0, 0, 8'h00, 3'd0, 6'b001000, 1, 1, 6'b001000, 8'hA5, 3'd3};
        vecs[4]  = '{0, 1, 8'h10, 3'd5, 6'b111111, 1, 1, 6'b000000, 8'hA5, 3'd3};
        vecs[5]  = '{0, 1, 8'h11, 3'd6, 6'b111111, 1, 1, 6'b100000, 8'h10, 3'd5};
        vecs[6]  = '{0, 1, 8'h12, 3'd7, 6'b111111, 1, 1, 6'b100000, 8'h11, 3'd5};
        vecs[7]  = '{0, 0, 8'h00, 3'd0, 6'b111111, 1, 1, 6'b100000, 8'h12, 3'd5};
        vecs[8]  = '{0, 1, 8'h01, 3'd0, 6'b000000, 1, 1, 6'b000000, 8'h12, 3'd5};
        vecs[9]  = '{0, 1, 8'h02, 3'd1, 6'b000000, 1, 1, 6'b000001, 8'h01, 3'd0};
        vecs[10] = '{0, 1, 8'h03, 3'd2, 6'b000010, 1, 0, 6'b000001, 8'h01, 3'd0};
        vecs[11] = '{0, 1, 8'h03, 3'd2, 6'b000010, 1, 0, 6'b000001, 8'h01, 3'd0};
        vecs[12] = '{0, 0, 8'h00, 3'd0, 6'b000001, 1, 0, 6'b000001, 8'h01, 3'd0};
        vecs[13] = '{0, 0, 8'h00, 3'd0, 6'b000000, 1, 1, 6'b000010, 8'h02, 3'd1};
        vecs[14] = '{0, 0, 8'h00, 3'd0, 6'b000010, 1, 1, 6'b000010, 8'h02, 3'd1};
        vecs[15] = '{0, 0, 8'h00, 3'd0, 6'b000000, 1, 1, 6'b000000, 8'h02, 3'd1};
        vecs[16] = '{0, 1, 8'hAA, 3'd4, 6'b000000, 1, 1, 6'b000000, 8'h02, 3'd1};
        vecs[17] = '{0, 1, 8'hBB, 3'd0, 6'b000000, 1, 1, 6'b010000, 8'hAA, 3'd4};
        vecs[18] = '{1, 1, 8'hCC, 3'd0, 6'b111111, 1, 0, 6'b010000, 8'hAA, 3'd4};
        vecs[19] = '{0, 0, 8'h00, 3'd0, 6'b111111, 1, 1, 6'b000000, 8'h00, 3'd0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            in_sel    = vecs[i].sel;
            out_ready = vecs[i].ordy;
            #1;
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].erdy));
            if (vecs[i].chk_out) begin
                check("out_valid", i, 32'(out_valid), 32'(vecs[i].eov));
                check("out_data", i, 32'(out_data), 32'(vecs[i].edat));
                check("out_dst", i, 32'(out_dst), 32'(vecs[i].edst));
            end
        end

        // Streaming: one payload per cycle, all consumers ready.
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            rst       = 1'b0;
            in_valid  = (i < 16);
            in_data   = 8'(i);
            in_sel    = 3'(i % 6);
            out_ready = 6'b111111;
            #1;
            check("stream_in_ready", i, 32'(in_ready), 32'd1);
            if (i == 0) begin
                check("stream_out_valid", i, 32'(out_valid), 32'd0);
            end else begin
                check("stream_out_valid", i, 32'(out_valid),
                      32'(6'(1) << ((i - 1) % 6)));
                check("stream_out_data", i, 32'(out_data), 32'(i - 1));
                check("stream_out_dst", i, 32'(out_dst), 32'((i - 1) % 6));
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("stream_drained", 17, 32'(out_valid), 32'd0);
        check("stream_last_data", 17, 32'(out_data), 32'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
